grad_window_feeder: RTL and testbench
=====================================

# grad_window_feeder

Producer side of the right-image gradient window path. It accepts a raster stream of gradient pixels and keeps the two previous image rows in internal line memories. For each pixel it emits three vertically aligned samples (row r-2, r-1, r) together with a shift-enable strobe. This drives the 258-column shift-register window that consumes `linebuffer0/1/2` and `clken`.

## Interface
- `PIXEL_WIDTH`, 11, bits per gradient pixel
- `IMG_WIDTH`, 640, pixels per row (≥2)
- `IMG_HEIGHT`, 480, rows per frame (≥3)
- `COL_BITS`, 10, column counter width, ≥ clog2(IMG_WIDTH)
- `ROW_BITS`, 9, row counter width, ≥ clog2(IMG_HEIGHT)

Ports:
- `clock` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse that (re)starts a frame.
- `pix_in` in PIXEL_WIDTH: incoming gradient pixel.
- `pix_valid` in 1: `pix_in` is valid this cycle. There is no backpressure.
- `linebuffer0` out PIXEL_WIDTH: pixel at (r-2, c), top row.
- `linebuffer1` out PIXEL_WIDTH: pixel at (r-1, c).
- `linebuffer2` out PIXEL_WIDTH: pixel at (r, c), current row.
- `clken` out 1: the three linebuffer outputs are valid and the window must shift.
- `col_cnt` out COL_BITS: column c of the sample currently on the outputs.
- `row_cnt` out ROW_BITS: row r of the sample currently on the outputs.
- `line_end` out 1: pulse coincident with the output of column IMG_WIDTH-1.
- `frame_done` out 1: pulse coincident with the output of the last pixel of the frame.

## Operation
- The FSM has three states: IDLE, FILL, STREAM.
  - IDLE: `pix_valid` is ignored. `frame_start` moves to FILL, with write row=0 and col=0.
  - FILL: covers rows 0 and 1. Pixels are written to memory and `clken` stays 0. Completing row 1 moves to STREAM.
  - STREAM: covers rows 2 .. IMG_HEIGHT-1. Every accepted pixel produces `clken`=1. Completing row IMG_HEIGHT-1 returns to IDLE.
- There are two line memories, each IMG_WIDTH deep and PIXEL_WIDTH wide. `mem_a` holds row r-1 and `mem_b` holds row r-2.
- On an accepted pixel at column c, all of the following happen in the same cycle:
  - Read `mem_a[c]` and `mem_b[c]`.
  - Write `mem_b[c] <= mem_a[c]` (old value) and `mem_a[c] <= pix_in`.
  - Register the outputs: `linebuffer2 <= pix_in`, `linebuffer1 <= mem_a[c]`, `linebuffer0 <= mem_b[c]`.
- Column counter:
  - Increments per accepted pixel.
  - At IMG_WIDTH-1 it wraps to 0 and the row counter increments.
  - The registered `col_cnt` and `row_cnt` outputs show the coordinates of the emitted sample.
- Boundary cases:
  - `frame_start` together with `pix_valid`: the pixel is accepted as (0,0).
  - `frame_start` mid-frame (FILL or STREAM): counters clear and the state becomes FILL. That cycle's pixel, if valid, is (0,0). Memory contents are not cleared; they are overwritten by the new rows.
  - `frame_start` in the same cycle as the last pixel of a frame: the last pixel completes normally (`clken`, `line_end`, `frame_done` asserted) and the new frame starts in FILL.
- Memory contents are not reset. Only registers are reset.

## Timing
- Latency: `pix_valid` sampled at edge k → `linebuffer*`, `clken`, `col_cnt`, `row_cnt`, `line_end` and `frame_done` are updated at edge k and held through cycle k+1.
- `clken`, `line_end` and `frame_done` are single-cycle pulses. They deassert in any cycle with no accepted pixel.
- `line_end` asserts for every row end, including FILL rows, where `clken` is 0.
- `linebuffer*` hold their last value when no pixel is accepted.
- Reset values: `linebuffer0/1/2` = 0, `clken` = 0, `col_cnt` = 0, `row_cnt` = 0, `line_end` = 0, `frame_done` = 0, state = IDLE.
- Reset asserted mid-frame: all of the above apply immediately (asynchronous), and no pulse is emitted after release until a new `frame_start`.
- Throughput: one pixel per clock, sustained, with any gap pattern on `pix_valid`.

## Test plan
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=4, with pixel value = row*16 + col.
- **Full frame, back-to-back:** `frame_start` + 16 valid pixels → `clken` is 0 for the first 8 pixels, then 1 for 8 pixels. At (2,1): `linebuffer2/1/0` = 0x21/0x11/0x01. At (3,3): 0x33/0x23/0x13. `frame_done` asserts exactly once, with (3,3).
- **Gapped input:** same frame with `pix_valid` toggling 1,0,1,0 → identical output sequence. `clken` is never high in a gap cycle. `line_end` asserts 4 times.
- **Pixels before `frame_start`:** 5 valid pixels in IDLE → no outputs change and `clken` stays 0. A subsequent frame still outputs 0x21/0x11/0x01 at (2,1).
- **Restart mid-frame:** `frame_start` after 10 pixels, then a full frame of values +0x100 → the first `clken` arrives only at the new (2,0), carrying 0x120/0x110/0x100.
- **Async reset in STREAM:** `rst` pulsed at pixel (2,2) → all outputs read 0 within the reset cycle, state is IDLE, and pixels are ignored until `frame_start`.
- **Boundary coincidence:** `frame_start` in the cycle after the last pixel (3,3) → `frame_done` is emitted once, and the new frame's (0,0) is accepted with no lost or duplicated `clken`.

Source files
------------

// File: rtl/grad_window_feeder.sv
// Gradient window feeder: turns a raster pixel stream into three vertically aligned
// samples (rows r-2, r-1, r) using two line memories, plus a window shift strobe.
module grad_window_feeder #(
  parameter int PIXEL_WIDTH = 11,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int COL_BITS    = 10,
  parameter int ROW_BITS    = 9
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic [PIXEL_WIDTH-1:0] pix_in,
  input  logic                   pix_valid,
  output logic [PIXEL_WIDTH-1:0] linebuffer0,
  output logic [PIXEL_WIDTH-1:0] linebuffer1,
  output logic [PIXEL_WIDTH-1:0] linebuffer2,
  output logic                   clken,
  output logic [COL_BITS-1:0]    col_cnt,
  output logic [ROW_BITS-1:0]    row_cnt,
  output logic                   line_end,
  output logic                   frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } state_t;

  localparam logic [COL_BITS-1:0] LAST_COL      = COL_BITS'(IMG_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW      = ROW_BITS'(IMG_HEIGHT - 1);
  localparam logic [ROW_BITS-1:0] LAST_FILL_ROW = ROW_BITS'(1);

  state_t                state;
  logic [COL_BITS-1:0]   wr_col;
  logic [ROW_BITS-1:0]   wr_row;

  // mem_a holds row r-1, mem_b holds row r-2
  logic [PIXEL_WIDTH-1:0] mem_a [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] mem_b [IMG_WIDTH];

  logic                   last_pix;
  logic                   restart;
  logic                   accept;
  logic                   row_done;
  state_t                 eff_state;
  logic [COL_BITS-1:0]    cur_col;
  logic [ROW_BITS-1:0]    cur_row;
  logic [PIXEL_WIDTH-1:0] rd_a;
  logic [PIXEL_WIDTH-1:0] rd_b;

  // A frame_start landing on the final pixel lets that pixel finish the old frame;
  // any other frame_start restarts at (0,0) in this very cycle.
  // NOTE: every always_comb output is assigned unconditionally so no latch is inferred.
  always_comb begin
    last_pix  = (state == STREAM) && (wr_col == LAST_COL) && (wr_row == LAST_ROW);
    restart   = frame_start && !(pix_valid && last_pix);
    eff_state = restart ? FILL : state;
    cur_col   = restart ? '0 : wr_col;
    cur_row   = restart ? '0 : wr_row;
    accept    = pix_valid && (eff_state != IDLE);
    row_done  = accept && (cur_col == LAST_COL);
  end

  assign rd_a = mem_a[cur_col];
  assign rd_b = mem_b[cur_col];

  // NOTE: line memories carry no reset; stale rows are simply overwritten by new ones.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem_b[cur_col] <= rd_a;
      mem_a[cur_col] <= pix_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_col      <= '0;
      wr_row      <= '0;
      linebuffer0 <= '0;
      linebuffer1 <= '0;
      linebuffer2 <= '0;
      clken       <= 1'b0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      line_end    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      clken      <= 1'b0;
      line_end   <= 1'b0;
      frame_done <= 1'b0;
      state      <= eff_state;
      wr_col     <= cur_col;
      wr_row     <= cur_row;
      if (accept) begin
        linebuffer2 <= pix_in;
        linebuffer1 <= rd_a;
        linebuffer0 <= rd_b;
        clken       <= (eff_state == STREAM);
        col_cnt     <= cur_col;
        row_cnt     <= cur_row;
        line_end    <= row_done;
        frame_done  <= row_done && (cur_row == LAST_ROW);
        if (row_done) begin
          wr_col <= '0;
          if (cur_row == LAST_ROW) begin
            wr_row <= '0;
            state  <= frame_start ? FILL : IDLE;
          end else begin
            wr_row <= cur_row + 1'b1;
            if (cur_row == LAST_FILL_ROW) state <= STREAM;
          end
        end else begin
          wr_col <= cur_col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_grad_window_feeder.sv
// Self-checking bench for grad_window_feeder on a 4x4 image, against a
// per-column history model driven by a linear pixel index.
module tb_grad_window_feeder;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 11;
  localparam int CB = 2;
  localparam int RB = 2;

  logic          clock = 1'b0;
  logic          rst   = 1'b1;
  logic          frame_start = 1'b0;
  logic [PW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic [PW-1:0] linebuffer0, linebuffer1, linebuffer2;
  logic          clken, line_end, frame_done;
  logic [CB-1:0] col_cnt;
  logic [RB-1:0] row_cnt;

  grad_window_feeder #(
    .PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_BITS(CB), .ROW_BITS(RB)
  ) dut (
    .clock(clock), .rst(rst), .frame_start(frame_start), .pix_in(pix_in),
    .pix_valid(pix_valid), .linebuffer0(linebuffer0), .linebuffer1(linebuffer1),
    .linebuffer2(linebuffer2), .clken(clken), .col_cnt(col_cnt), .row_cnt(row_cnt),
    .line_end(line_end), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Model: each column remembers the last two values written to it.
  logic [PW-1:0] h_new [W];
  logic [PW-1:0] h_old [W];
  bit            k_new [W];
  bit            k_old [W];
  bit            m_active = 0;
  int            m_n = 0;

  logic [PW-1:0] e_lb0 = '0, e_lb1 = '0, e_lb2 = '0;
  bit            e_k0 = 1, e_k1 = 1;
  logic          e_clk = 0, e_le = 0, e_fd = 0;
  logic [CB-1:0] e_col = '0;
  logic [RB-1:0] e_row = '0;

  int cnt_clk = 0, cnt_le = 0, cnt_fd = 0, gap_clk = 0;

  logic [PW-1:0] obs_lb0 [W*H];
  logic [PW-1:0] obs_lb1 [W*H];
  logic [PW-1:0] obs_lb2 [W*H];
  logic          obs_clk [W*H];
  logic          obs_fd  [W*H];

  task automatic model_reset();
    e_lb0 = '0; e_lb1 = '0; e_lb2 = '0; e_k0 = 1; e_k1 = 1;
    e_clk = 0; e_le = 0; e_fd = 0; e_col = '0; e_row = '0;
    m_active = 0; m_n = 0;
  endtask

  task automatic clear_counts();
    cnt_clk = 0; cnt_le = 0; cnt_fd = 0; gap_clk = 0;
  endtask

  // One clock: drive, advance the model, compare every output.
  task automatic step(input logic fs, input logic v, input logic [PW-1:0] p);
    bit last;
    int r, c;
    frame_start = fs; pix_valid = v; pix_in = p;
    @(posedge clock);
    #1;
    frame_start = 1'b0; pix_valid = 1'b0;
    last = m_active && (m_n == W*H - 1);
    if (fs && !(v && last)) begin
      m_active = 1; m_n = 0;
    end
    if (v && m_active) begin
      r = m_n / W; c = m_n % W;
      e_lb2 = p; e_lb1 = h_new[c]; e_k1 = k_new[c]; e_lb0 = h_old[c]; e_k0 = k_old[c];
      h_old[c] = h_new[c]; k_old[c] = k_new[c]; h_new[c] = p; k_new[c] = 1;
      e_clk = (r >= 2); e_le = (c == W - 1); e_fd = (m_n == W*H - 1);
      e_col = CB'(c); e_row = RB'(r);
      m_n++;
      if (m_n == W*H) begin
        m_n = 0; m_active = fs;
      end
    end else begin
      e_clk = 0; e_le = 0; e_fd = 0;
    end
    if (clken) cnt_clk++;
    if (line_end) cnt_le++;
    if (frame_done) cnt_fd++;
    if (!v && clken) gap_clk++;
    n_vec++; if (linebuffer2 !== e_lb2) begin n_err++; $display("FAIL lb2: got %0h expected %0h", linebuffer2, e_lb2); end
    if (e_k1) begin n_vec++; if (linebuffer1 !== e_lb1) begin n_err++; $display("FAIL lb1: got %0h expected %0h", linebuffer1, e_lb1); end end
    if (e_k0) begin n_vec++; if (linebuffer0 !== e_lb0) begin n_err++; $display("FAIL lb0: got %0h expected %0h", linebuffer0, e_lb0); end end
    n_vec++; if (clken !== e_clk) begin n_err++; $display("FAIL clken: got %0b expected %0b", clken, e_clk); end
    n_vec++; if (line_end !== e_le) begin n_err++; $display("FAIL line_end: got %0b expected %0b", line_end, e_le); end
    n_vec++; if (frame_done !== e_fd) begin n_err++; $display("FAIL frame_done: got %0b expected %0b", frame_done, e_fd); end
    n_vec++; if (col_cnt !== e_col) begin n_err++; $display("FAIL col_cnt: got %0d expected %0d", col_cnt, e_col); end
    n_vec++; if (row_cnt !== e_row) begin n_err++; $display("FAIL row_cnt: got %0d expected %0d", row_cnt, e_row); end
  endtask

  // fs_mode: 0 = frame_start in its own cycle, 1 = with first pixel, 2 = none
  task automatic run_frame(input int base, input bit gapped, input int fs_mode,
                           input bit fs_on_last, input int npix);
    logic [PW-1:0] p;
    logic fs;
    if (fs_mode == 0) step(1'b1, 1'b0, '0);
    for (int i = 0; i < npix; i++) begin
      p  = PW'(base + (i / W) * 16 + (i % W));
      fs = (i == 0 && fs_mode == 1) || (i == npix - 1 && fs_on_last);
      step(fs, 1'b1, p);
      obs_lb0[i] = linebuffer0; obs_lb1[i] = linebuffer1; obs_lb2[i] = linebuffer2;
      obs_clk[i] = clken; obs_fd[i] = frame_done;
      if (gapped) step(1'b0, 1'b0, PW'($urandom));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_vec++; if (linebuffer0 !== '0) begin n_err++; $display("FAIL reset_lb0: got %0h expected 0", linebuffer0); end
    n_vec++; if (linebuffer1 !== '0) begin n_err++; $display("FAIL reset_lb1: got %0h expected 0", linebuffer1); end
    n_vec++; if (linebuffer2 !== '0) begin n_err++; $display("FAIL reset_lb2: got %0h expected 0", linebuffer2); end
    n_vec++; if ({clken, line_end, frame_done} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b expected 000", {clken, line_end, frame_done}); end
    n_vec++; if ({col_cnt, row_cnt} !== '0) begin n_err++; $display("FAIL reset_cnt: got %0h expected 0", {col_cnt, row_cnt}); end
    @(negedge clock);
    rst = 1'b0;
    model_reset();
    step(1'b0, 1'b1, 11'h7ff);
  endtask

  task automatic test_full_frame();
    int nclk_fill = 0, nclk_stream = 0;
    clear_counts();
    run_frame(0, 0, 0, 0, 16);
    for (int i = 0; i < 8; i++) if (obs_clk[i]) nclk_fill++;
    for (int i = 8; i < 16; i++) if (obs_clk[i]) nclk_stream++;
    n_vec++; if (nclk_fill !== 0) begin n_err++; $display("FAIL full_fill_clken: got %0d expected 0", nclk_fill); end
    n_vec++; if (nclk_stream !== 8) begin n_err++; $display("FAIL full_stream_clken: got %0d expected 8", nclk_stream); end
    n_vec++; if ({obs_lb2[9], obs_lb1[9], obs_lb0[9]} !== {11'h21, 11'h11, 11'h01}) begin
      n_err++; $display("FAIL full_2_1: got %0h/%0h/%0h expected 21/11/1", obs_lb2[9], obs_lb1[9], obs_lb0[9]); end
    n_vec++; if ({obs_lb2[15], obs_lb1[15], obs_lb0[15]} !== {11'h33, 11'h23, 11'h13}) begin
      n_err++; $display("FAIL full_3_3: got %0h/%0h/%0h expected 33/23/13", obs_lb2[15], obs_lb1[15], obs_lb0[15]); end
    n_vec++; if (cnt_fd !== 1 || obs_fd[15] !== 1'b1) begin n_err++; $display("FAIL full_frame_done: got %0d (last %0b) expected 1 (last 1)", cnt_fd, obs_fd[15]); end
  endtask

  task automatic test_gapped();
    clear_counts();
    run_frame(0, 1, 0, 0, 16);
    n_vec++; if (gap_clk !== 0) begin n_err++; $display("FAIL gap_clken: got %0d expected 0", gap_clk); end
    n_vec++; if (cnt_le !== 4) begin n_err++; $display("FAIL gap_line_end: got %0d expected 4", cnt_le); end
    n_vec++; if (cnt_clk !== 8) begin n_err++; $display("FAIL gap_clken_total: got %0d expected 8", cnt_clk); end
    n_vec++; if ({obs_lb2[9], obs_lb1[9], obs_lb0[9]} !== {11'h21, 11'h11, 11'h01}) begin
      n_err++; $display("FAIL gap_2_1: got %0h/%0h/%0h expected 21/11/1", obs_lb2[9], obs_lb1[9], obs_lb0[9]); end
  endtask

  task automatic test_idle_pixels();
    clear_counts();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, PW'($urandom));
    n_vec++; if (cnt_clk + cnt_le + cnt_fd !== 0) begin n_err++; $display("FAIL idle_pulses: got %0d expected 0", cnt_clk + cnt_le + cnt_fd); end
    run_frame(0, 0, 0, 0, 16);
    n_vec++; if ({obs_lb2[9], obs_lb1[9], obs_lb0[9]} !== {11'h21, 11'h11, 11'h01}) begin
      n_err++; $display("FAIL idle_2_1: got %0h/%0h/%0h expected 21/11/1", obs_lb2[9], obs_lb1[9], obs_lb0[9]); end
  endtask

  task automatic test_restart();
    int first = -1;
    run_frame(0, 0, 0, 0, 10);
    run_frame(32'h100, 0, 0, 0, 16);
    for (int i = 15; i >= 0; i--) if (obs_clk[i]) first = i;
    n_vec++; if (first !== 8) begin n_err++; $display("FAIL restart_first_clken: got %0d expected 8", first); end
    n_vec++; if ({obs_lb2[8], obs_lb1[8], obs_lb0[8]} !== {11'h120, 11'h110, 11'h100}) begin
      n_err++; $display("FAIL restart_2_0: got %0h/%0h/%0h expected 120/110/100", obs_lb2[8], obs_lb1[8], obs_lb0[8]); end
  endtask

  task automatic test_async_reset();
    run_frame(0, 0, 0, 0, 11);
    #3;
    rst = 1'b1;
    #1;
    n_vec++; if ({linebuffer0, linebuffer1, linebuffer2} !== '0) begin n_err++; $display("FAIL areset_lb: got %0h expected 0", {linebuffer0, linebuffer1, linebuffer2}); end
    n_vec++; if ({clken, line_end, frame_done, col_cnt, row_cnt} !== '0) begin n_err++; $display("FAIL areset_ctl: got %0h expected 0", {clken, line_end, frame_done, col_cnt, row_cnt}); end
    model_reset();
    @(posedge clock);
    #1;
    rst = 1'b0;
    clear_counts();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, PW'($urandom));
    n_vec++; if (cnt_clk + cnt_le + cnt_fd !== 0) begin n_err++; $display("FAIL areset_ignored: got %0d expected 0", cnt_clk + cnt_le + cnt_fd); end
  endtask

  task automatic test_boundary();
    clear_counts();
    run_frame(32'h200, 0, 0, 0, 16);
    run_frame(32'h300, 0, 1, 0, 16);
    n_vec++; if (cnt_fd !== 2) begin n_err++; $display("FAIL bound_next_fd: got %0d expected 2", cnt_fd); end
    n_vec++; if (cnt_clk !== 16) begin n_err++; $display("FAIL bound_next_clken: got %0d expected 16", cnt_clk); end
    clear_counts();
    run_frame(32'h400, 0, 0, 1, 16);
    run_frame(32'h500, 0, 2, 0, 16);
    n_vec++; if (cnt_fd !== 2) begin n_err++; $display("FAIL bound_same_fd: got %0d expected 2", cnt_fd); end
    n_vec++; if (cnt_clk !== 16) begin n_err++; $display("FAIL bound_same_clken: got %0d expected 16", cnt_clk); end
  endtask

  task automatic test_random();
    step(1'b1, 1'b1, PW'($urandom));
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 60) == 0, $urandom_range(0, 2) != 0, PW'($urandom));
  endtask

  initial begin
    for (int c = 0; c < W; c++) begin
      h_new[c] = '0; h_old[c] = '0; k_new[c] = 0; k_old[c] = 0;
    end
    test_reset();
    test_full_frame();
    test_gapped();
    test_idle_pixels();
    test_restart();
    test_async_reset();
    test_boundary();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
